// File: rtl/memcore_pkg.sv
// Shared constants and helpers for the pipelined true dual-port BRAM core.
package memcore_pkg;

   localparam int WM_READ_FIRST    = 0;
   localparam int WM_WRITE_FIRST   = 1;
   localparam int WM_NO_CHANGE     = 2;
   localparam int MAX_READ_LATENCY = 4;

   function automatic int num_bytes(input int data_w, input int byte_w);
      return data_w / byte_w;
   endfunction

endpackage

// File: rtl/memcore_rd_pipe.sv
// Valid-qualified data delay line; data stages only load when the incoming stage
// is valid, so the final stage holds the last delivered word.
module memcore_rd_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vld_i,
   input  logic [DATA_WIDTH-1:0] dat_i,
   output logic                  vld_o,
   output logic [DATA_WIDTH-1:0] dat_o
);

   if (DEPTH == 0) begin : g_bypass
      // Upstream register already holds on invalid; nothing to add here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign vld_o          = vld_i;
      assign dat_o          = dat_i;
   end else begin : g_line
      logic [DEPTH-1:0]                 vld_pipe_q;
      logic [DEPTH-1:0][DATA_WIDTH-1:0] dat_pipe_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
         end else begin
            vld_pipe_q[0] <= vld_i;
            if (vld_i) dat_pipe_q[0] <= dat_i;
            for (int i = 1; i < DEPTH; i++) begin
               vld_pipe_q[i] <= vld_pipe_q[i-1];
               if (vld_pipe_q[i-1]) dat_pipe_q[i] <= dat_pipe_q[i-1];
            end
         end
      end

      assign vld_o = vld_pipe_q[DEPTH-1];
      assign dat_o = dat_pipe_q[DEPTH-1];
   end

endmodule

// File: rtl/memcore_bram_true_pipelined.sv
// True dual-port BRAM with byte enables, selectable read-during-write mode and a
// valid-tracked output pipeline. Optional collision detect: MEMCORE_COLLISION_DETECT_EN.
module memcore_bram_true_pipelined
   import memcore_pkg::*;
#(
   parameter  int DATA_WIDTH    = 32,
   parameter  int BYTE_WIDTH    = 8,
   parameter  int ADDRESS_WIDTH = 6,
   parameter  int ADDRESS_RANGE = 64,
   parameter  int READ_LATENCY  = 1,
   parameter  int WRITE_MODE    = WM_READ_FIRST,
   localparam int NUM_BYTES     = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [ADDRESS_WIDTH-1:0] address0,
   input  logic                     ce0,
   input  logic [DATA_WIDTH-1:0]    d0,
   input  logic [NUM_BYTES-1:0]     we0,
   output logic [DATA_WIDTH-1:0]    q0,
   output logic                     q0_valid,
   input  logic [ADDRESS_WIDTH-1:0] address1,
   input  logic                     ce1,
   input  logic [DATA_WIDTH-1:0]    d1,
   input  logic [NUM_BYTES-1:0]     we1,
   output logic [DATA_WIDTH-1:0]    q1,
   output logic                     q1_valid
`ifdef MEMCORE_COLLISION_DETECT_EN
   ,
   output logic                     collision,
   output logic [15:0]              collision_count
`endif
);

   localparam int NP  = 2;
   localparam int BW  = BYTE_WIDTH;
   localparam int LAT = (READ_LATENCY < 1) ? 1 :
                        (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

   logic [DATA_WIDTH-1:0] mem [ADDRESS_RANGE];

   logic [NP-1:0][ADDRESS_WIDTH-1:0] addr;
   logic [NP-1:0]                    ce;
   logic [NP-1:0][NUM_BYTES-1:0]     we;
   logic [NP-1:0][DATA_WIDTH-1:0]    wdat;

   assign addr = {address1, address0};
   assign ce   = {ce1, ce0};
   assign we   = {we1, we0};
   assign wdat = {d1, d0};

   logic [NP-1:0]                 rd, wr, in_rng, ev_vld_d;
   logic [NP-1:0][DATA_WIDTH-1:0] old_word, merged, ev_dat_d;
   logic [NP-1:0]                 s1_vld_q;
   logic [NP-1:0][DATA_WIDTH-1:0] s1_dat_q;
   logic [NP-1:0]                 q_vld;
   logic [NP-1:0][DATA_WIDTH-1:0] q_dat;

   always_comb begin
      rd       = '0;
      wr       = '0;
      in_rng   = '0;
      old_word = '0;
      merged   = '0;
      ev_vld_d = '0;
      ev_dat_d = '0;
      for (int p = 0; p < NP; p++) begin
         rd[p]       = ce[p] & ~|we[p];
         wr[p]       = ce[p] & |we[p];
         in_rng[p]   = int'(addr[p]) < ADDRESS_RANGE;
         old_word[p] = in_rng[p] ? mem[addr[p]] : '0;
         for (int b = 0; b < NUM_BYTES; b++)
            merged[p][b*BW +: BW] = we[p][b] ? wdat[p][b*BW +: BW] : old_word[p][b*BW +: BW];
         // Pre-edge array contents give the old word to a cross-port reader for free.
         ev_vld_d[p] = rd[p] | (wr[p] & (WRITE_MODE != WM_NO_CHANGE));
         ev_dat_d[p] = (wr[p] && WRITE_MODE == WM_WRITE_FIRST) ? merged[p] : old_word[p];
      end
   end

   // Port 1 is committed first so port 0's enabled bytes win on a shared address.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         for (int p = NP - 1; p >= 0; p--) begin
            if (wr[p] && in_rng[p]) begin
               for (int b = 0; b < NUM_BYTES; b++)
                  if (we[p][b]) mem[addr[p]][b*BW +: BW] <= wdat[p][b*BW +: BW];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld_q <= '0;
         s1_dat_q <= '0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            s1_vld_q[p] <= ev_vld_d[p];
            if (ev_vld_d[p]) s1_dat_q[p] <= ev_dat_d[p];
         end
      end
   end

   for (genvar g = 0; g < NP; g++) begin : g_port
      memcore_rd_pipe #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (LAT - 1)
      ) u_pipe (
         .clk   (clk),
         .rst_n (reset_n),
         .vld_i (s1_vld_q[g]),
         .dat_i (s1_dat_q[g]),
         .vld_o (q_vld[g]),
         .dat_o (q_dat[g])
      );
   end

   assign q0       = q_dat[0];
   assign q0_valid = q_vld[0];
   assign q1       = q_dat[1];
   assign q1_valid = q_vld[1];

`ifdef MEMCORE_COLLISION_DETECT_EN
   logic        coll_d, coll_q;
   logic [15:0] coll_cnt_q;

   assign coll_d = ce[0] & ce[1] & (addr[0] == addr[1]) & (wr[0] | wr[1]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         coll_q     <= 1'b0;
         coll_cnt_q <= '0;
      end else begin
         coll_q <= coll_d;
         if (coll_d && coll_cnt_q != 16'hFFFF) coll_cnt_q <= coll_cnt_q + 16'd1;
      end
   end

   assign collision       = coll_q;
   assign collision_count = coll_cnt_q;
`endif

endmodule
